exclusive_max_pw: RTL and testbench

Race-logic "exclusive max" primitive for the pulse-width temporal coding domain. Within each gamma cycle, q fires at the later of the two input arrival times. If both inputs arrive on the same clock edge, q does not fire at all. The block sits in the temporal compute fabric beside min/max/inhibit primitives and is cleared at the start of every gamma cycle by the global reset.

---
 rtl/exclusive_max_pw.sv | 83 ++++++++
 tb/tb_exclusive_max_pw.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/exclusive_max_pw.sv
// Race-logic exclusive max: q pulses for PULSE_WIDTH cycles at the later of the two
// arrival times in a gamma cycle, and never fires when both inputs arrive on the same edge.
module exclusive_max_pw #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8
) (
    input  logic aclk,
    input  logic grst,
    input  logic a,
    input  logic b,
    output logic q
);

    localparam int CW = $clog2(PULSE_WIDTH + 1);
    localparam int TW = (GAMMA_CYCLE_WIDTH > 1) ? $clog2(GAMMA_CYCLE_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_WIDTH - 1);
    localparam logic [TW-1:0] TS_MAX   = TW'(GAMMA_CYCLE_WIDTH - 1);

    logic [1:0]    in_vec;
    logic [1:0]    arrive;
    logic [1:0]    seen_reg, seen_next;
    logic          tie_reg, tie_next;
    logic          fired_reg, fired_next;
    logic          q_reg, q_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [TW-1:0] ts_reg, ts_next;
    logic          fire;

    assign in_vec = {b, a};

    // Only the first sampled high of each input is an arrival; later activity is ignored.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_input
            assign arrive[gi]    = in_vec[gi] & ~seen_reg[gi];
            assign seen_next[gi] = seen_reg[gi] | in_vec[gi];
        end
    endgenerate

    // A simultaneous arrival can only be both-arrive-now, which sets tie instead of firing.
    assign fire = ~fired_reg & ~tie_reg &
                  ((arrive[0] & seen_reg[1]) | (arrive[1] & seen_reg[0]));

    always_comb begin
        tie_next   = tie_reg | (&arrive);
        fired_next = fired_reg;
        q_next     = q_reg;
        cnt_next   = cnt_reg;
        ts_next    = (ts_reg == TS_MAX) ? ts_reg : ts_reg + 1'b1;

        if (fire) begin
            q_next     = 1'b1;
            fired_next = 1'b1;
            cnt_next   = CNT_LOAD;
        end else if (q_reg) begin
            if (cnt_reg == '0) begin
                q_next = 1'b0;
            end else begin
                cnt_next = cnt_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge grst) begin
        if (!grst) begin
            seen_reg  <= '0;
            tie_reg   <= 1'b0;
            fired_reg <= 1'b0;
            q_reg     <= 1'b0;
            cnt_reg   <= '0;
            ts_reg    <= '0;
        end else begin
            seen_reg  <= seen_next;
            tie_reg   <= tie_next;
            fired_reg <= fired_next;
            q_reg     <= q_next;
            cnt_reg   <= cnt_next;
            ts_reg    <= ts_next;
        end
    end

    assign q = q_reg;

endmodule

// File: tb/tb_exclusive_max_pw.sv
// Scoreboard bench for exclusive_max_pw: whole-cycle input waveforms are generated,
// the expected q per edge is derived from the arrival times and checked by a monitor.
module tb_exclusive_max_pw;

    localparam int GW = 16;
    localparam int PW = 8;
    localparam int N  = 20;

    typedef struct {
        int   cyc;
        int   edge_n;
        logic exp_q;
    } exp_t;

    logic aclk = 1'b0;
    logic grst = 1'b0;
    logic a    = 1'b0;
    logic b    = 1'b0;
    logic q;

    exp_t exp_q[$];
    int   vectors   = 0;
    int   miscompares = 0;
    int   cycle_id  = 0;

    exclusive_max_pw #(
        .GAMMA_CYCLE_WIDTH(GW),
        .PULSE_WIDTH      (PW)
    ) dut (
        .aclk(aclk),
        .grst(grst),
        .a   (a),
        .b   (b),
        .q   (q)
    );

    always #5 aclk = ~aclk;

    // Arrival = first sampled-high edge; q high on edges L..L+PW-1 for a non-tied pair.
    function automatic logic [N-1:0] model(input logic [N-1:0] aw, input logic [N-1:0] bw);
        int ta = -1;
        int tb = -1;
        int l;
        logic [N-1:0] r = '0;
        for (int e = N - 1; e >= 0; e--) begin
            if (aw[e]) ta = e;
            if (bw[e]) tb = e;
        end
        if (ta >= 0 && tb >= 0 && ta != tb) begin
            l = (ta > tb) ? ta : tb;
            for (int e = l; e < l + PW && e < N; e++) r[e] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [N-1:0] pulse(input int start, input int len);
        logic [N-1:0] r = '0;
        for (int e = start; e < start + len && e < N; e++) r[e] = 1'b1;
        return r;
    endfunction

    // Starts just after a falling edge: one reset cycle, then n_edges sampled edges.
    task automatic run_cycle(input logic [N-1:0] aw, input logic [N-1:0] bw, input int n_edges);
        logic [N-1:0] ex;
        ex = model(aw, bw);
        cycle_id++;
        $display("cycle %0d a=%b b=%b exp=%b", cycle_id, aw, bw, ex);
        grst = 1'b0;
        a = aw[0];
        b = bw[0];
        @(negedge aclk);
        vectors++;
        if (q !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_q cycle %0d: got %b expected 0", cycle_id, q);
        end
        grst = 1'b1;
        for (int e = 0; e < n_edges; e++) begin
            a = aw[e];
            b = bw[e];
            exp_q.push_back('{cyc: cycle_id, edge_n: e, exp_q: ex[e]});
            @(negedge aclk);
        end
    endtask

    // Monitor: one expected q value per sampling edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge aclk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                vectors++;
                if (q !== x.exp_q) begin
                    miscompares++;
                    $display("FAIL q_edge cycle %0d edge %0d: got %b expected %b",
                             x.cyc, x.edge_n, q, x.exp_q);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] aw, bw, mask;
        int ta, tb;

        repeat (3) @(negedge aclk);

        run_cycle('0, '0, N);
        run_cycle(pulse(2, 8), pulse(4, 8), N);
        run_cycle(pulse(4, 8), pulse(2, 8), N);
        run_cycle(pulse(2, 8), pulse(2, 8), N);
        run_cycle(pulse(2, 8), pulse(5, 8), N);
        run_cycle(pulse(2, 8), '0, N);
        run_cycle(pulse(2, 2) | pulse(6, 2), '0, N);
        run_cycle(pulse(2, 2) | pulse(6, 3), pulse(4, 8), N);
        run_cycle(pulse(0, 3), pulse(1, 1), N);

        // Pulse starts at edge 4; reset drops asynchronously after edge 7.
        run_cycle(pulse(2, 8), pulse(4, 8), 8);
        grst = 1'b0;
        #1;
        vectors++;
        if (q !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_q: got %b expected 0", q);
        end
        @(negedge aclk);
        run_cycle('0, '0, N);

        for (int k = 0; k < 40; k++) begin
            aw = '0;
            bw = '0;
            ta = $urandom_range(0, 11);
            tb = ($urandom_range(0, 3) == 0) ? ta : $urandom_range(0, 11);
            if ($urandom_range(0, 7) != 0) aw = pulse(ta, $urandom_range(1, 8));
            if ($urandom_range(0, 7) != 0) bw = pulse(tb, $urandom_range(1, 8));
            if ($urandom_range(0, 1) == 1 && aw != '0) begin
                mask = {N{1'b1}} << (ta + 1);
                aw = aw | (N'($urandom) & mask);
            end
            if ($urandom_range(0, 1) == 1 && bw != '0) begin
                mask = {N{1'b1}} << (tb + 1);
                bw = bw | (N'($urandom) & mask);
            end
            run_cycle(aw, bw, N);
        end

        grst = 1'b0;
        a = 1'b0;
        b = 1'b0;
        repeat (3) @(negedge aclk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
